// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered self-decoding immediate generator with 2-entry skid buffer (optional IMM_GEN_ZIMM_EN)
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_unknown,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_Z    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  logic [31:0]      dec_imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_unknown;

  // Skid entry holds already-decoded fields; it is full exactly when in_ready is low.
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_unknown;
  logic [31:0]      skid_instr;
  logic [TAG_W-1:0] skid_tag;

  logic accept;
  logic out_free;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Decode the format from the opcode and build a 32-bit immediate whose bit 31 is the sign.
  always_comb begin
    dec_imm32   = '0;
    dec_fmt     = FMT_NONE;
    dec_unknown = 1'b0;
    case (in_instr[6:0])
      7'h13, 7'h03, 7'h67: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'h23: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'h63: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'b0};
      end
      7'h6F: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
        if (in_instr[14]) begin
          dec_fmt   = FMT_Z;
          dec_imm32 = {27'b0, in_instr[19:15]};
        end else begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
`else
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
      end
      7'h33, 7'h0F: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_fmt     = FMT_NONE;
        dec_unknown = 1'b1;
      end
    endcase
  end

  // Widen to XLEN from bit 31 (zimm has bit 31 clear, so it zero-extends).
  assign dec_imm = XLEN'($signed(dec_imm32));

  // Output register plus skid register; flush beats accept, skid drains before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_unknown  <= 1'b0;
      out_instr    <= '0;
      out_tag      <= '0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_unknown <= 1'b0;
      skid_instr   <= '0;
      skid_tag     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (out_free) begin
      if (!in_ready) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_fmt     <= skid_fmt;
        out_unknown <= skid_unknown;
        out_instr   <= skid_instr;
        out_tag     <= skid_tag;
        in_ready    <= 1'b1;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_unknown <= dec_unknown;
        out_instr   <= in_instr;
        out_tag     <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_unknown <= dec_unknown;
      skid_instr   <= in_instr;
      skid_tag     <= in_tag;
      in_ready     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, unk32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [31:0] ins32, tag32;

  logic        rdy64, vld64, unk64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [31:0] ins64, tag64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } entry_t;

  entry_t q[$];
  int     tag_ctr = 1;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_unknown(unk32), .out_instr(ins32), .out_tag(tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_unknown(unk64), .out_instr(ins64), .out_tag(tag64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Interpret a bits-wide unsigned field value as two's complement.
  function automatic longint sx(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half * 2) : v;
  endfunction

  // Reference decode straight from the ISA field layout, using integer arithmetic.
  function automatic void ref_dec(input logic [31:0] ins, output longint imm,
                                  output int fmt, output bit unk);
    imm = 0; fmt = 7; unk = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin fmt = 0; imm = sx(longint'(ins[31:20]), 12); end
      7'h23: begin fmt = 1; imm = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
      7'h63: begin
        fmt = 2;
        imm = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                 longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin fmt = 3; imm = sx(longint'(ins[31:12]) * 4096, 32); end
      7'h6F: begin
        fmt = 4;
        imm = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                 longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
        if (ins[14]) begin fmt = 5; imm = longint'(ins[19:15]); end
        else begin fmt = 0; imm = sx(longint'(ins[31:20]), 12); end
`else
        fmt = 0; imm = sx(longint'(ins[31:20]), 12);
`endif
      end
      7'h33, 7'h0F: begin fmt = 7; end
      default: begin fmt = 7; unk = 1; end
    endcase
  endfunction

  task automatic check_outputs();
    longint      e_imm;
    int          e_fmt;
    bit          e_unk;
    logic [63:0] e_bits;
    chk("out_valid32", 64'(vld32), 64'(q.size() > 0));
    chk("out_valid64", 64'(vld64), 64'(q.size() > 0));
    chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      ref_dec(q[0].instr, e_imm, e_fmt, e_unk);
      e_bits = e_imm;
      chk("imm32", 64'(imm32), {32'b0, e_bits[31:0]});
      chk("imm64", imm64, e_bits);
      chk("fmt32", 64'(fmt32), 64'(e_fmt));
      chk("fmt64", 64'(fmt64), 64'(e_fmt));
      chk("unknown", 64'(unk32), 64'(e_unk));
      chk("unknown64", 64'(unk64), 64'(e_unk));
      chk("instr", 64'(ins32), 64'(q[0].instr));
      chk("tag", 64'(tag32), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
    end
  endtask

  // Check current outputs, drive one cycle of inputs, advance the model, wait for next negedge.
  task automatic tick(input bit iv, input logic [31:0] ins, input bit ordy,
                      input bit fl, output bit acc);
    bit     xfer;
    entry_t e;
    check_outputs();
    in_valid  = iv;
    in_instr  = ins;
    in_tag    = tag_ctr;
    out_ready = ordy;
    flush     = fl;
    acc  = iv && (q.size() < 2) && !fl;
    xfer = (q.size() > 0) && ordy;
    if (fl) q.delete();
    else begin
      if (xfer) void'(q.pop_front());
      if (acc) begin
        e.instr = ins;
        e.tag   = tag_ctr;
        q.push_back(e);
      end
    end
    if (iv) tag_ctr++;
    @(negedge clk);
  endtask

  logic [31:0] stream [4] = '{32'hFE112E23, 32'h00208463, 32'h001000EF, 32'h12345037};
  logic [31:0] s_imm  [4] = '{32'hFFFFFFFC, 32'h00000008, 32'h00000800, 32'h12345000};
  logic [2:0]  s_fmt  [4] = '{3'd1, 3'd2, 3'd4, 3'd3};
  logic [6:0]  ops    [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                               7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] r;
    logic [6:0]  op;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(vld32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", 64'(fmt32), 64'd7);
    chk("rst_unknown", 64'(unk32), 64'd0);
    chk("rst_instr", 64'(ins32), 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI -1: one cycle latency
    tick(1, 32'hFFF00093, 1, 0, acc);
    chk("addi_valid", 64'(vld32), 64'd1);
    chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(fmt32), 64'd0);
    tick(0, 0, 1, 0, acc);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      tick(1, stream[i], 1, 0, acc);
      chk($sformatf("stream_imm%0d", i), 64'(imm32), 64'(s_imm[i]));
      chk($sformatf("stream_fmt%0d", i), 64'(fmt32), 64'(s_fmt[i]));
    end
    tick(0, 0, 1, 0, acc);

    // XLEN=64 LUI and unknown opcode
    tick(1, 32'h800000B7, 1, 0, acc);
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    tick(1, 32'h0000007F, 1, 0, acc);
    chk("unk_fmt", 64'(fmt64), 64'd7);
    chk("unk_flag", 64'(unk64), 64'd1);
    chk("unk_imm", imm64, 64'd0);

    // CSRRWI x0, 0x300, 31
    tick(1, 32'h300FD073, 1, 0, acc);
`ifdef IMM_GEN_ZIMM_EN
    chk("csrrwi_fmt", 64'(fmt32), 64'd5);
    chk("csrrwi_imm", 64'(imm32), 64'h1F);
`else
    chk("csrrwi_fmt", 64'(fmt32), 64'd0);
    chk("csrrwi_imm", 64'(imm32), 64'h300);
`endif
    tick(0, 0, 1, 0, acc);

    // back-pressure: out_ready low in cycles 2..4
    idx = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(idx < 4, stream[idx % 4], !(c >= 2 && c <= 4), 0, acc);
      if (acc) idx++;
      if (c == 4) chk("stall_in_ready", 64'(rdy32), 64'd0);
    end
    chk("stall_all_accepted", 64'(idx), 64'd4);

    // flush with two entries buffered and input presented
    tick(1, 32'h00100093, 0, 0, acc);
    tick(1, 32'h00200093, 0, 0, acc);
    tick(1, 32'h00300093, 0, 1, acc);
    chk("flush_valid", 64'(vld32), 64'd0);
    chk("flush_ready", 64'(rdy32), 64'd1);
    for (int c = 0; c < 3; c++) tick(0, 0, 1, 0, acc);

    // asynchronous reset mid-stream
    tick(1, 32'h00400093, 0, 0, acc);
    tick(1, 32'h00500093, 0, 0, acc);
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid32", 64'(vld32), 64'd0);
    chk("async_rst_valid64", 64'(vld64), 64'd0);
    chk("async_rst_ready", 64'(rdy32), 64'd1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      r  = $urandom;
      idx = $urandom_range(0, 12);
      if (idx == 12) op = r[6:0];
      else op = ops[idx];
      tick($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, acc);
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
